pattern_merge_sched: RTL and testbench

//  Time-shares one merged-pattern datapath (register-bounded pattern_*_* netlist) between NREQ requesters.

---
 rtl/pattern_merge_sched.sv | 149 ++++++++++++++
 tb/tb_pattern_merge_sched.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_merge_sched.sv
// Round-robin scheduler that time-shares one pipelined pattern datapath between requesters.
// Optional perf counters (grant_cnt, stall_cnt) are built when PMS_PERF_CNT_EN is defined.
module pattern_merge_sched #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IN_W  = 11,
  parameter int unsigned OUT_W = 9,
  parameter int unsigned LAT   = 2
) (
  input  logic                     blif_clk_net,
  input  logic                     blif_reset_net,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*IN_W-1:0]     req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic [IN_W-1:0]          dp_in,
  input  logic [OUT_W-1:0]         dp_out,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [OUT_W-1:0]         rsp_data,
  output logic                     busy
`ifdef PMS_PERF_CNT_EN
  ,
  output logic [15:0]              grant_cnt,
  output logic [15:0]              stall_cnt
`endif
);

  localparam int unsigned IdW  = $clog2(NREQ);
  localparam int unsigned SumW = IdW + 1;
  localparam int unsigned CntW = $clog2(LAT + 1);

  typedef enum logic [1:0] {StIdle, StHold, StResp} state_e;

  state_e            state_q, state_d;
  logic [IdW-1:0]    ptr_q, ptr_d;
  logic [IdW-1:0]    id_q, id_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IN_W-1:0]   dp_in_q, dp_in_d;
  logic [OUT_W-1:0]  rsp_data_q, rsp_data_d;
  logic              rsp_valid_q, rsp_valid_d;

  logic              grant_found;
  logic [IdW-1:0]    grant_idx;
  logic [SumW-1:0]   sum;
  logic [IN_W-1:0]   req_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign req_arr[g] = req_data[g*IN_W +: IN_W];
  end

  // First valid requester at or after the pointer, wrapping modulo NREQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    sum         = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      sum = {1'b0, ptr_q} + SumW'(i);
      if (sum >= SumW'(NREQ)) sum = sum - SumW'(NREQ);
      if (!grant_found && req_valid[sum[IdW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = sum[IdW-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    dp_in_d     = dp_in_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
    req_ready   = '0;
    case (state_q)
      StIdle: begin
        if (grant_found) begin
          // Accept pulse is suppressed while reset is held so nothing is lost.
          req_ready[grant_idx] = !blif_reset_net;
          dp_in_d = req_arr[grant_idx];
          id_d    = grant_idx;
          ptr_d   = (grant_idx == IdW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
          cnt_d   = CntW'(LAT);
          state_d = StHold;
        end
      end
      StHold: begin
        if (cnt_q == '0) begin
          rsp_data_d  = dp_out;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge blif_clk_net) begin
    if (blif_reset_net) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      id_q        <= '0;
      cnt_q       <= '0;
      dp_in_q     <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      dp_in_q     <= dp_in_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign dp_in     = dp_in_q;
  assign rsp_id    = id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_valid = rsp_valid_q;
  assign busy      = (state_q != StIdle);

`ifdef PMS_PERF_CNT_EN
  logic accept, stall;
  assign accept = (state_q == StIdle) && grant_found;
  assign stall  = (state_q == StResp) && !rsp_ready;

  // Both counters saturate rather than wrap.
  always_ff @(posedge blif_clk_net) begin
    if (blif_reset_net) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (accept && (grant_cnt != 16'hFFFF)) grant_cnt <= grant_cnt + 16'd1;
      if (stall && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pattern_merge_sched.sv
// Randomized and directed bench for pattern_merge_sched against a transaction-level model.
// Perf-counter checks are compiled in when PMS_PERF_CNT_EN is defined.
module tb_pattern_merge_sched;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned IN_W  = 11;
  localparam int unsigned OUT_W = 9;
  localparam int unsigned LAT   = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*IN_W-1:0]  req_data;
  logic [NREQ-1:0]       req_ready;
  logic [IN_W-1:0]       dp_in;
  logic [OUT_W-1:0]      dp_out;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [1:0]            rsp_id;
  logic [OUT_W-1:0]      rsp_data;
  logic                  busy;
`ifdef PMS_PERF_CNT_EN
  logic [15:0]           grant_cnt, stall_cnt;
`endif

  always #5 clk = ~clk;

  pattern_merge_sched #(.NREQ(NREQ), .IN_W(IN_W), .OUT_W(OUT_W), .LAT(LAT)) dut (
    .blif_clk_net   (clk),
    .blif_reset_net (rst),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .dp_in          (dp_in),
    .dp_out         (dp_out),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_id         (rsp_id),
    .rsp_data       (rsp_data),
    .busy           (busy)
`ifdef PMS_PERF_CNT_EN
    ,
    .grant_cnt      (grant_cnt),
    .stall_cnt      (stall_cnt)
`endif
  );

  // Stand-in pattern netlist: combinational function behind LAT=2 register stages.
  function automatic logic [OUT_W-1:0] f_dp(input logic [IN_W-1:0] x);
    return (x[8:0] ^ {x[10:9], x[6:0]}) + 9'd37;
  endfunction

  logic [OUT_W-1:0] p1, p2;
  always_ff @(posedge clk) begin
    p1 <= f_dp(dp_in);
    p2 <= p1;
  end
  assign dp_out = p2;

  int vectors = 0;
  int miscompares = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transaction-level model: mode 0 idle, 1 waiting for datapath, 2 response offered.
  int               mode, m_ptr, m_rsp_at, cyc;
  logic [IN_W-1:0]  m_dp;
  logic [1:0]       m_id;
  logic [OUT_W-1:0] m_rdata;
  logic [15:0]      m_gcnt, m_scnt;

  logic [IN_W-1:0]  dat [NREQ];
  int               g_id_q[$], g_cyc_q[$], r_cyc_q[$], r_id_q[$];
  logic [OUT_W-1:0] r_data_q[$];
  logic             prev_rv;
  int               obs_busy;

  task automatic clear_obs();
    g_id_q.delete(); g_cyc_q.delete(); r_cyc_q.delete(); r_id_q.delete(); r_data_q.delete();
    obs_busy = 0;
  endtask

  task automatic step(input logic r, input logic [NREQ-1:0] v, input logic rr);
    int exp_g;
    logic [NREQ-1:0] exp_rdy;
    rst       = r;
    req_valid = v;
    rsp_ready = rr;
    for (int i = 0; i < NREQ; i++) req_data[i*IN_W +: IN_W] = dat[i];
    @(negedge clk);
    exp_g = -1;
    if (!r && mode == 0)
      for (int i = 0; i < NREQ; i++)
        if (exp_g < 0 && v[(m_ptr + i) % NREQ]) exp_g = (m_ptr + i) % NREQ;
    exp_rdy = '0;
    if (exp_g >= 0) exp_rdy[exp_g] = 1'b1;
    check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
    check_eq("busy", 32'(busy), 32'(mode != 0));
    check_eq("rsp_valid", 32'(rsp_valid), 32'(mode == 2));
    check_eq("rsp_id", 32'(rsp_id), 32'(m_id));
    check_eq("rsp_data", 32'(rsp_data), 32'(m_rdata));
    check_eq("dp_in", 32'(dp_in), 32'(m_dp));
`ifdef PMS_PERF_CNT_EN
    check_eq("grant_cnt", 32'(grant_cnt), 32'(m_gcnt));
    check_eq("stall_cnt", 32'(stall_cnt), 32'(m_scnt));
`endif
    for (int i = 0; i < NREQ; i++)
      if (req_ready[i]) begin g_id_q.push_back(i); g_cyc_q.push_back(cyc); end
    if (rsp_valid === 1'b1 && !prev_rv) begin
      r_cyc_q.push_back(cyc); r_id_q.push_back(int'(rsp_id)); r_data_q.push_back(rsp_data);
    end
    prev_rv = (rsp_valid === 1'b1);
    if (busy === 1'b1) obs_busy++;
    if (r) begin
      mode = 0; m_ptr = 0; m_dp = '0; m_id = '0; m_rdata = '0; m_gcnt = '0; m_scnt = '0;
    end else begin
      case (mode)
        0: if (exp_g >= 0) begin
          m_dp     = dat[exp_g];
          m_id     = 2'(exp_g);
          m_ptr    = (exp_g + 1) % NREQ;
          m_rsp_at = cyc + 2 + LAT;
          if (m_gcnt != 16'hFFFF) m_gcnt = m_gcnt + 1;
          mode     = 1;
        end
        1: if (cyc + 1 == m_rsp_at) begin
          m_rdata = f_dp(m_dp);
          mode    = 2;
        end
        default: if (rr) mode = 0;
                 else if (m_scnt != 16'hFFFF) m_scnt = m_scnt + 1;
      endcase
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < NREQ; i++) dat[i] = IN_W'($urandom);
  endtask

  logic [15:0] snap;

  initial begin
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; req_data = '0;
    rand_data();
    prev_rv = 1'b0;
    mode = 0; m_ptr = 0; m_rsp_at = 0; cyc = 0;
    m_dp = '0; m_id = '0; m_rdata = '0; m_gcnt = '0; m_scnt = '0;
    clear_obs();
    repeat (2) @(posedge clk);
    #1;

    // Reset held with everyone requesting, then continuous requests: 0,1,2,3,0,1 every 5 cycles.
    repeat (3) step(1'b1, 4'hF, 1'b1);
    clear_obs();
    step(1'b0, 4'hF, 1'b1);
    check_eq("t1_first_grant", 32'(g_id_q.size() > 0 ? g_id_q[0] : -1), 32'd0);
    repeat (27) step(1'b0, 4'hF, 1'b1);
    check_eq("t3_count_ge6", 32'(g_id_q.size() >= 6), 32'd1);
    for (int k = 0; k < 6; k++)
      if (k < g_id_q.size()) check_eq("t3_order", 32'(g_id_q[k]), 32'(k % 4));
    for (int k = 1; k < 6; k++)
      if (k < g_cyc_q.size()) check_eq("t3_spacing", 32'(g_cyc_q[k] - g_cyc_q[k-1]), 32'd5);
    repeat (8) step(1'b0, 4'h0, 1'b1);

    // Lone request 2 with fixed data.
    dat[2] = 11'h5A5;
    clear_obs();
    step(1'b0, 4'b0100, 1'b1);
    repeat (8) step(1'b0, 4'h0, 1'b1);
    check_eq("t2_grants", 32'(g_id_q.size()), 32'd1);
    check_eq("t2_rsps", 32'(r_cyc_q.size()), 32'd1);
    if (g_cyc_q.size() > 0 && r_cyc_q.size() > 0) begin
      check_eq("t2_latency", 32'(r_cyc_q[0] - g_cyc_q[0]), 32'd4);
      check_eq("t2_id", 32'(r_id_q[0]), 32'd2);
      check_eq("t2_data", 32'(r_data_q[0]), 32'(f_dp(11'h5A5)));
    end
    check_eq("t2_busy_cycles", 32'(obs_busy), 32'd4);

    // Consumer stalls for 6 response cycles while others keep requesting.
    clear_obs();
`ifdef PMS_PERF_CNT_EN
    snap = stall_cnt;
`else
    snap = '0;
`endif
    step(1'b0, 4'b0001, 1'b0);
    repeat (9) step(1'b0, 4'hF, 1'b0);
    step(1'b0, 4'h0, 1'b1);
    repeat (6) step(1'b0, 4'h0, 1'b1);
    check_eq("t4_grants", 32'(g_id_q.size()), 32'd1);
`ifdef PMS_PERF_CNT_EN
    check_eq("t4_stall_delta", 32'(stall_cnt - snap), 32'd6);
`endif

    // Reset during the hold phase abandons the job and restarts priority at 0.
    clear_obs();
    step(1'b0, 4'b0010, 1'b1);
    repeat (2) step(1'b0, 4'h0, 1'b1);
    step(1'b1, 4'h0, 1'b1);
    step(1'b0, 4'b1010, 1'b1);
    repeat (8) step(1'b0, 4'h0, 1'b1);
    check_eq("t5_grants", 32'(g_id_q.size()), 32'd2);
    if (g_id_q.size() >= 2) check_eq("t5_regrant", 32'(g_id_q[1]), 32'd1);
    check_eq("t5_rsps", 32'(r_cyc_q.size()), 32'd1);

    // Short-lived request while busy is never served.
    clear_obs();
`ifdef PMS_PERF_CNT_EN
    snap = grant_cnt;
`endif
    step(1'b0, 4'b0001, 1'b1);
    step(1'b0, 4'b0010, 1'b1);
    repeat (8) step(1'b0, 4'h0, 1'b1);
    check_eq("t6_grants", 32'(g_id_q.size()), 32'd1);
    if (g_id_q.size() > 0) check_eq("t6_id", 32'(g_id_q[0]), 32'd0);
`ifdef PMS_PERF_CNT_EN
    check_eq("t6_grant_delta", 32'(grant_cnt - snap), 32'd1);
`endif

    // Random traffic with occasional resets and consumer back-pressure.
    for (int n = 0; n < 3000; n++) begin
      rand_data();
      step($urandom_range(0, 99) == 0, NREQ'($urandom_range(0, 15)), $urandom_range(0, 2) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
